// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared definitions for the integer convolution controller:
//                controller state encoding and the fixed weight formula.
//  Revision    : 1.0  initial release
// ============================================================================
package conv_pkg;

    // Controller states
    localparam int         c_state_bits = 2;
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_load    = 2'd1;
    localparam logic [1:0] c_st_compute = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    // Fixed weight set: the tap position is folded into a small index and
    // re-centred so the result is a two's complement value of wbits bits.
    function automatic int weight_fn(input int k, input int c, input int r,
                                     input int s, input int ksize, input int wbits);
        int v;
        v = (k + c + r * ksize + s) % (1 << wbits);
        return v - (1 << (wbits - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_weight_rom.sv
`default_nettype none
// ============================================================================
//  Module      : conv_weight_rom
//  Description : Combinational weight table. For one kernel tap (r,s) it
//                returns the weights of every kernel/channel lane at once,
//                lane index = k*CHANNEL + c.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_weight_rom
    import conv_pkg::*;
#(
    parameter int WEIGHT_BITS   = 3,
    parameter int KERNEL_SIZE   = 5,
    parameter int KERNEL_NUMBER = 1,
    parameter int CHANNEL       = 3
) (
    input  logic [$clog2(KERNEL_SIZE)-1:0]                i_tap_r,
    input  logic [$clog2(KERNEL_SIZE)-1:0]                i_tap_s,
    output logic [KERNEL_NUMBER*CHANNEL*WEIGHT_BITS-1:0]  o_weights
);

    for (genvar k = 0; k < KERNEL_NUMBER; k++) begin : g_kern
        for (genvar c = 0; c < CHANNEL; c++) begin : g_chan
            assign o_weights[(k*CHANNEL+c)*WEIGHT_BITS +: WEIGHT_BITS] =
                WEIGHT_BITS'(weight_fn(k, c, int'(i_tap_r), int'(i_tap_s),
                                       KERNEL_SIZE, WEIGHT_BITS));
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_control_integer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_control_integer
//  Description : Integer 2-D convolution controller. Loads a multi-channel
//                picture, then convolves it ("same" zero padding) with the
//                fixed weight set, one kernel tap per cycle, emitting one
//                signed result per output pixel in raster order.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_control_integer
    import conv_pkg::*;
#(
    parameter int PIC_BITS         = 2,
    parameter int WEIGHT_BITS      = 3,
    parameter int KERNEL_SIZE      = 5,
    parameter int PIC_SIZE         = 28,
    parameter int KERNEL_NUMBER    = 1,
    parameter int CHANNEL          = 3,
    parameter int CONV_RESULT_BITS = $clog2(KERNEL_SIZE*KERNEL_SIZE*KERNEL_NUMBER*CHANNEL)
                                     + WEIGHT_BITS + 1,
    parameter int ADDR_BITS        = $clog2(PIC_SIZE*PIC_SIZE)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PIC_BITS-1:0]                pic,
    input  logic                               pic_valid,
    input  logic                               conv_start,
    output logic                               need_pic,
    output logic                               conv_finish,
    output logic                               conv_result_valid,
    output logic signed [CONV_RESULT_BITS-1:0] conv_result,
    output logic [ADDR_BITS-1:0]               conv_result_addr
);

    localparam int c_pixels   = PIC_SIZE * PIC_SIZE;
    localparam int c_pad      = (KERNEL_SIZE - 1) / 2;
    localparam int c_lanes    = KERNEL_NUMBER * CHANNEL;
    localparam int c_pos_bits = $clog2(PIC_SIZE);
    localparam int c_tap_bits = $clog2(KERNEL_SIZE);
    localparam int c_ch_bits  = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;

    logic [c_state_bits-1:0]             r_state;
    logic [c_state_bits-1:0]             w_next_state;

    logic [c_ch_bits-1:0]                r_ch;
    logic [ADDR_BITS-1:0]                r_ld_idx;
    logic [PIC_BITS-1:0]                 r_pic_buf [CHANNEL][c_pixels];

    logic [c_pos_bits-1:0]               r_row;
    logic [c_pos_bits-1:0]               r_col;
    logic [c_tap_bits-1:0]               r_tap_r;
    logic [c_tap_bits-1:0]               r_tap_s;
    logic signed [CONV_RESULT_BITS-1:0]  r_acc;
    logic                                r_frame_done;

    // Finished output waits here one cycle so result, address and valid
    // leave the block together.
    logic signed [CONV_RESULT_BITS-1:0]  r_hold_res;
    logic [ADDR_BITS-1:0]                r_hold_addr;
    logic                                r_hold_vld;

    logic                                w_last_pixel;
    logic                                w_last_tap;
    logic                                w_mac_en;
    logic [ADDR_BITS-1:0]                w_out_addr;
    logic                                w_in_range;
    logic [ADDR_BITS-1:0]                w_pix_addr;
    logic [c_lanes*WEIGHT_BITS-1:0]      w_weights;
    logic signed [CONV_RESULT_BITS-1:0]  w_prod    [c_lanes];
    logic signed [CONV_RESULT_BITS-1:0]  w_partial [c_lanes+1];
    logic signed [CONV_RESULT_BITS-1:0]  w_tap_sum;

    assign w_last_pixel = (r_state == c_st_load) && pic_valid &&
                          (r_ch == c_ch_bits'(CHANNEL - 1)) &&
                          (r_ld_idx == ADDR_BITS'(c_pixels - 1));
    assign w_last_tap   = (r_tap_r == c_tap_bits'(KERNEL_SIZE - 1)) &&
                          (r_tap_s == c_tap_bits'(KERNEL_SIZE - 1));
    assign w_mac_en     = (r_state == c_st_compute) && !r_frame_done;
    assign w_out_addr   = ADDR_BITS'(r_row) * ADDR_BITS'(PIC_SIZE) + ADDR_BITS'(r_col);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_next_state;
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:    if (conv_start)   w_next_state = c_st_load;
            c_st_load:    if (w_last_pixel) w_next_state = c_st_compute;
            c_st_compute: if (r_frame_done) w_next_state = c_st_done;
            c_st_done:                      w_next_state = c_st_idle;
            default:                        w_next_state = c_st_idle;
        endcase
    end

    // Load counters: channel-major, then raster position within the channel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch     <= '0;
            r_ld_idx <= '0;
        end else if (r_state == c_st_load && pic_valid) begin
            if (r_ld_idx == ADDR_BITS'(c_pixels - 1)) begin
                r_ld_idx <= '0;
                r_ch     <= (r_ch == c_ch_bits'(CHANNEL - 1)) ? '0 : r_ch + 1'b1;
            end else begin
                r_ld_idx <= r_ld_idx + 1'b1;
            end
        end
    end

    // Picture buffer write port (contents are not reset)
    always_ff @(posedge clk) begin
        if (r_state == c_st_load && pic_valid)
            r_pic_buf[r_ch][r_ld_idx] <= pic;
    end

    // Source pixel position of the current tap, with zero padding outside
    always_comb begin : p_src
        int py;
        int px;
        py         = int'(r_row) + int'(r_tap_r) - c_pad;
        px         = int'(r_col) + int'(r_tap_s) - c_pad;
        w_in_range = (py >= 0) && (py < PIC_SIZE) && (px >= 0) && (px < PIC_SIZE);
        w_pix_addr = w_in_range ? ADDR_BITS'(py * PIC_SIZE + px) : '0;
    end

    conv_weight_rom #(
        .WEIGHT_BITS   (WEIGHT_BITS),
        .KERNEL_SIZE   (KERNEL_SIZE),
        .KERNEL_NUMBER (KERNEL_NUMBER),
        .CHANNEL       (CHANNEL)
    ) u_weight_rom (
        .i_tap_r   (r_tap_r),
        .i_tap_s   (r_tap_s),
        .o_weights (w_weights)
    );

    // One multiplier per kernel/channel lane; pixel is zero-extended
    for (genvar k = 0; k < KERNEL_NUMBER; k++) begin : g_mac_kern
        for (genvar c = 0; c < CHANNEL; c++) begin : g_mac_chan
            logic [PIC_BITS-1:0]           w_pix;
            logic signed [WEIGHT_BITS-1:0] w_wt;
            assign w_pix = w_in_range ? r_pic_buf[c][w_pix_addr] : '0;
            assign w_wt  = w_weights[(k*CHANNEL+c)*WEIGHT_BITS +: WEIGHT_BITS];
            assign w_prod[k*CHANNEL+c] =
                $signed({{(CONV_RESULT_BITS-PIC_BITS){1'b0}}, w_pix}) *
                $signed({{(CONV_RESULT_BITS-WEIGHT_BITS){w_wt[WEIGHT_BITS-1]}}, w_wt});
        end
    end

    assign w_partial[0] = '0;
    for (genvar i = 0; i < c_lanes; i++) begin : g_sum
        assign w_partial[i+1] = w_partial[i] + w_prod[i];
    end
    assign w_tap_sum = w_partial[c_lanes];

    // Tap/position sequencing and accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_tap_r      <= '0;
            r_tap_s      <= '0;
            r_acc        <= '0;
            r_frame_done <= 1'b0;
            r_hold_res   <= '0;
            r_hold_addr  <= '0;
            r_hold_vld   <= 1'b0;
        end else begin
            r_hold_vld <= 1'b0;
            if (r_state == c_st_load) begin
                r_row        <= '0;
                r_col        <= '0;
                r_tap_r      <= '0;
                r_tap_s      <= '0;
                r_acc        <= '0;
                r_frame_done <= 1'b0;
            end else if (w_mac_en) begin
                if (w_last_tap) begin
                    r_acc       <= '0;
                    r_hold_res  <= r_acc + w_tap_sum;
                    r_hold_addr <= w_out_addr;
                    r_hold_vld  <= 1'b1;
                    r_tap_r     <= '0;
                    r_tap_s     <= '0;
                    if (r_col == c_pos_bits'(PIC_SIZE - 1)) begin
                        r_col <= '0;
                        if (r_row == c_pos_bits'(PIC_SIZE - 1)) begin
                            r_row        <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end else begin
                    r_acc <= r_acc + w_tap_sum;
                    if (r_tap_s == c_tap_bits'(KERNEL_SIZE - 1)) begin
                        r_tap_s <= '0;
                        r_tap_r <= r_tap_r + 1'b1;
                    end else begin
                        r_tap_s <= r_tap_s + 1'b1;
                    end
                end
            end
        end
    end

    // Registered outputs; result/address hold between valid pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            need_pic          <= 1'b0;
            conv_finish       <= 1'b0;
            conv_result_valid <= 1'b0;
            conv_result       <= '0;
            conv_result_addr  <= '0;
        end else begin
            need_pic          <= (w_next_state == c_st_load);
            conv_finish       <= (r_state == c_st_done);
            conv_result_valid <= r_hold_vld;
            if (r_hold_vld) begin
                conv_result      <= r_hold_res;
                conv_result_addr <= r_hold_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_control_integer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_control_integer
//  Description : Self-checking bench for conv_control_integer with a direct
//                arithmetic convolution model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_control_integer;

    localparam int N     = 28;
    localparam int K     = 5;
    localparam int C     = 3;
    localparam int KN    = 1;
    localparam int PIX   = N * N;
    localparam int TOTAL = C * PIX;
    localparam int PADW  = (K - 1) / 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        pic = '0;
    logic              pic_valid = 1'b0;
    logic              conv_start = 1'b0;
    logic              need_pic;
    logic              conv_finish;
    logic              conv_result_valid;
    logic signed [10:0] conv_result;
    logic [9:0]        conv_result_addr;

    conv_control_integer u_dut (
        .clk               (clk),
        .rst               (rst),
        .pic               (pic),
        .pic_valid         (pic_valid),
        .conv_start        (conv_start),
        .need_pic          (need_pic),
        .conv_finish       (conv_finish),
        .conv_result_valid (conv_result_valid),
        .conv_result       (conv_result),
        .conv_result_addr  (conv_result_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int res_q[$];
    int addr_q[$];
    int vcyc_q[$];
    int fin_q[$];

    // Capture every output pulse with the cycle it was seen in
    always @(negedge clk) begin
        if (conv_result_valid === 1'b1) begin
            res_q.push_back(int'(conv_result));
            addr_q.push_back(int'(conv_result_addr));
            vcyc_q.push_back(cyc);
        end
        if (conv_finish === 1'b1) fin_q.push_back(cyc);
    end

    int n_pass  = 0;
    int n_total = 0;

    int ref_pic [TOTAL];
    int exp_res [PIX];

    function automatic int ref_weight(input int k, input int c, input int r, input int s);
        return ((k + c + r * K + s) % 8) - 4;
    endfunction

    // Straight textbook convolution with zero padding
    function automatic void compute_expected();
        for (int row = 0; row < N; row++)
            for (int col = 0; col < N; col++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < KN; k++)
                    for (int c = 0; c < C; c++)
                        for (int r = 0; r < K; r++)
                            for (int s = 0; s < K; s++) begin
                                int y, x;
                                y = row + r - PADW;
                                x = col + s - PADW;
                                if (y >= 0 && y < N && x >= 0 && x < N)
                                    acc += ref_pic[c*PIX + y*N + x] * ref_weight(k, c, r, s);
                            end
                exp_res[row*N + col] = acc;
            end
    endfunction

    function automatic void clear_queues();
        res_q.delete();
        addr_q.delete();
        vcyc_q.delete();
        fin_q.delete();
    endfunction

    // Stream the reference picture; mode 0 = always valid, 1 = toggling, 2 = random
    task automatic load_frame(input int mode, input bit drop_start, output int last_cyc);
        int idx, budget;
        bit v, np, phase;
        idx = 0; budget = 0; phase = 1'b1; last_cyc = 0;
        while (idx < TOTAL && budget < 12000) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = phase; phase = ~phase; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            pic       = 2'(ref_pic[idx]);
            pic_valid = v;
            np        = need_pic;
            @(posedge clk); #1;
            budget++;
            if (np && v) begin
                idx++;
                if (drop_start) conv_start = 1'b0;
                if (idx == TOTAL) last_cyc = cyc;
            end
        end
        pic_valid = 1'b0;
        n_total++;
        if (idx < TOTAL) $display("FAIL load_timeout accepted=%0d required=%0d", idx, TOTAL);
        else n_pass++;
    endtask

    task automatic wait_finish(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 25000 && !ok; i++) begin
            @(negedge clk); #1;
            if (fin_q.size() > 0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; conv_start = 1'b0; pic_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++; if (need_pic !== 1'b0) $display("FAIL reset_need_pic got=%b exp=0", need_pic); else n_pass++;
        n_total++; if (conv_finish !== 1'b0) $display("FAIL reset_finish got=%b exp=0", conv_finish); else n_pass++;
        n_total++; if (conv_result_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", conv_result_valid); else n_pass++;
        n_total++; if (conv_result !== 11'sd0) $display("FAIL reset_result got=%0d exp=0", conv_result); else n_pass++;
        n_total++; if (conv_result_addr !== 10'd0) $display("FAIL reset_addr got=%0d exp=0", conv_result_addr); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Constant-one picture, pic_valid junk during compute, start released early
    task automatic test_ones();
        int last_cyc, bad, lat, fc;
        bit ok;
        for (int i = 0; i < TOTAL; i++) ref_pic[i] = 1;
        compute_expected();
        clear_queues();
        conv_start = 1'b1;
        load_frame(0, 1'b1, last_cyc);
        pic = 2'd3; pic_valid = 1'b1;
        @(negedge clk);
        n_total++; if (need_pic !== 1'b0) $display("FAIL ones_need_pic_drop got=%b exp=0", need_pic); else n_pass++;
        wait_finish(ok);
        pic_valid = 1'b0;
        n_total++; if (!ok) $display("FAIL ones_finish_timeout got=none exp=pulse"); else n_pass++;
        n_total++; if (res_q.size() != PIX) $display("FAIL ones_count got=%0d exp=%0d", res_q.size(), PIX); else n_pass++;
        for (int i = 0; i < res_q.size() && i < PIX; i++) begin
            n_total++; if (addr_q[i] != i) $display("FAIL ones_addr[%0d] got=%0d exp=%0d", i, addr_q[i], i); else n_pass++;
            n_total++; if (res_q[i] != exp_res[i]) $display("FAIL ones_result[%0d] got=%0d exp=%0d", i, res_q[i], exp_res[i]); else n_pass++;
        end
        n_total++; if (res_q.size() < 1 || res_q[0] != -11) $display("FAIL ones_corner got=%0d exp=-11", (res_q.size() > 0) ? res_q[0] : 9999); else n_pass++;
        n_total++; if (res_q.size() < 59 || res_q[58] != -45) $display("FAIL ones_interior got=%0d exp=-45", (res_q.size() > 58) ? res_q[58] : 9999); else n_pass++;
        lat = (vcyc_q.size() > 0) ? vcyc_q[0] - last_cyc : -1;
        n_total++; if (lat != 26) $display("FAIL ones_first_latency got=%0d exp=26", lat); else n_pass++;
        bad = 0;
        for (int i = 1; i < vcyc_q.size(); i++) if (vcyc_q[i] - vcyc_q[i-1] != 25) bad++;
        n_total++; if (bad != 0) $display("FAIL ones_spacing bad_gaps=%0d exp=0", bad); else n_pass++;
        fc = (fin_q.size() > 0 && vcyc_q.size() > 0) ? fin_q[0] - vcyc_q[vcyc_q.size()-1] : -1;
        n_total++; if (fc != 1) $display("FAIL ones_finish_delay got=%0d exp=1", fc); else n_pass++;
        repeat (5) @(negedge clk);
        #1;
        n_total++; if (fin_q.size() != 1) $display("FAIL ones_finish_pulses got=%0d exp=1", fin_q.size()); else n_pass++;
        n_total++; if (need_pic !== 1'b0) $display("FAIL ones_idle_need_pic got=%b exp=0", need_pic); else n_pass++;
    endtask

    task automatic test_reset_mid_compute();
        int last_cyc;
        for (int i = 0; i < TOTAL; i++) ref_pic[i] = 1;
        compute_expected();
        clear_queues();
        conv_start = 1'b1;
        load_frame(0, 1'b1, last_cyc);
        for (int i = 0; i < 200 && res_q.size() < 3; i++) begin @(negedge clk); #1; end
        n_total++; if (res_q.size() < 3 || res_q[2] != exp_res[2]) $display("FAIL midrst_pre_result got=%0d exp=%0d", (res_q.size() > 2) ? res_q[2] : 9999, exp_res[2]); else n_pass++;
        pic_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (need_pic !== 1'b0) $display("FAIL midrst_need_pic got=%b exp=0", need_pic); else n_pass++;
        n_total++; if (conv_result_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", conv_result_valid); else n_pass++;
        n_total++; if (conv_finish !== 1'b0) $display("FAIL midrst_finish got=%b exp=0", conv_finish); else n_pass++;
        n_total++; if (conv_result !== 11'sd0) $display("FAIL midrst_result got=%0d exp=0", conv_result); else n_pass++;
        n_total++; if (conv_result_addr !== 10'd0) $display("FAIL midrst_addr got=%0d exp=0", conv_result_addr); else n_pass++;
        rst = 1'b0;
        clear_queues();
        repeat (30) @(posedge clk);
        #1;
        pic_valid = 1'b0;
        n_total++; if (need_pic !== 1'b0) $display("FAIL midrst_idle_need_pic got=%b exp=0", need_pic); else n_pass++;
        n_total++; if (res_q.size() + fin_q.size() != 0) $display("FAIL midrst_idle_activity got=%0d exp=0", res_q.size() + fin_q.size()); else n_pass++;
    endtask

    // conv_start held: random frame then impulse frame with no gap
    task automatic test_back_to_back();
        int last_cyc, bad, lat, fc;
        bit ok;
        conv_start = 1'b1;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) begin
                for (int i = 0; i < TOTAL; i++) ref_pic[i] = int'($urandom_range(0, 3));
            end else begin
                for (int i = 0; i < TOTAL; i++) ref_pic[i] = 0;
                ref_pic[14*N + 14] = 3;
            end
            compute_expected();
            clear_queues();
            load_frame((f == 0) ? 2 : 1, f == 1, last_cyc);
            wait_finish(ok);
            n_total++; if (!ok) $display("FAIL b2b%0d_finish_timeout got=none exp=pulse", f); else n_pass++;
            n_total++; if (res_q.size() != PIX) $display("FAIL b2b%0d_count got=%0d exp=%0d", f, res_q.size(), PIX); else n_pass++;
            for (int i = 0; i < res_q.size() && i < PIX; i++) begin
                n_total++; if (addr_q[i] != i) $display("FAIL b2b%0d_addr[%0d] got=%0d exp=%0d", f, i, addr_q[i], i); else n_pass++;
                n_total++; if (res_q[i] != exp_res[i]) $display("FAIL b2b%0d_result[%0d] got=%0d exp=%0d", f, i, res_q[i], exp_res[i]); else n_pass++;
            end
            lat = (vcyc_q.size() > 0) ? vcyc_q[0] - last_cyc : -1;
            n_total++; if (lat != 26) $display("FAIL b2b%0d_first_latency got=%0d exp=26", f, lat); else n_pass++;
            bad = 0;
            for (int i = 1; i < vcyc_q.size(); i++) if (vcyc_q[i] - vcyc_q[i-1] != 25) bad++;
            n_total++; if (bad != 0) $display("FAIL b2b%0d_spacing bad_gaps=%0d exp=0", f, bad); else n_pass++;
            fc = (fin_q.size() > 0 && vcyc_q.size() > 0) ? fin_q[0] - vcyc_q[vcyc_q.size()-1] : -1;
            n_total++; if (fc != 1) $display("FAIL b2b%0d_finish_delay got=%0d exp=1", f, fc); else n_pass++;
            @(negedge clk); #1;
            n_total++; if (need_pic !== (f == 0)) $display("FAIL b2b%0d_need_pic_after_finish got=%b exp=%b", f, need_pic, f == 0); else n_pass++;
        end
        n_total++; if (res_q.size() < 378 || res_q[13*N+13] != -6) $display("FAIL impulse_tap33 got=%0d exp=-6", (res_q.size() > 377) ? res_q[13*N+13] : 9999); else n_pass++;
        n_total++; if (res_q.size() < 407 || res_q[14*N+14] != 0) $display("FAIL impulse_centre got=%0d exp=0", (res_q.size() > 406) ? res_q[14*N+14] : 9999); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ones();
        test_reset_mid_compute();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/conv_control_integer.md
Name: conv_control_integer

Overview:
Integer 2-D convolution controller for the CNN datapath. On start it requests a full multi-channel picture over a valid-qualified stream and stores it in an internal buffer. It then convolves the picture with a fixed on-chip weight set ("same" zero padding) and emits one signed result per output pixel, with its raster address. It sits between the picture source and the result memory/activation stage.

Parameters:
pic_bits, 2, unsigned pixel width
weight_bits, 3, signed weight width (two's complement)
kernel_size, 5, kernel height and width K (odd)
pic_size, 28, picture height and width N (square)
kernel_number, 1, number of kernels; their outputs are summed into one result
channel, 3, input channels C
conv_result_bits, $clog2(kernel_size*kernel_size*kernel_number*channel)+weight_bits+1 (=11), signed result width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
pic  in  pic_bits  unsigned input pixel
pic_valid  in  1  pic is valid this cycle
conv_start  in  1  start request, sampled in IDLE (level)
need_pic  out  1  block is accepting pixels
conv_finish  out  1  one-cycle pulse: whole frame done
conv_result_valid  out  1  one-cycle pulse per result
conv_result  out  conv_result_bits  signed convolution result
conv_result_addr  out  $clog2(pic_size*pic_size)  output index row*N+col

Behaviour:
- Reset: state IDLE; need_pic, conv_finish, conv_result_valid = 0; conv_result = 0; conv_result_addr = 0; all counters 0. Reset mid-LOAD or mid-COMPUTE aborts immediately; buffer contents are don't-care.
- States: IDLE -> LOAD -> COMPUTE -> DONE -> IDLE.
- IDLE: conv_start=1 at an edge -> LOAD next cycle.
- LOAD: need_pic=1 (registered, high from first LOAD cycle). Each edge with pic_valid=1 stores pic; order is channel-major, then row, then column (index c*N*N + r*N + x). pic_valid=0 stalls with no side effect. After pixel C*N*N-1 (2352nd) is accepted: need_pic=0 next cycle, -> COMPUTE.
- COMPUTE: outputs in raster order (row 0..N-1, col 0..N-1). Per output, exactly K*K cycles; one kernel tap (r,s) per cycle, all channels and kernels in parallel, accumulated in a conv_result_bits signed accumulator cleared at output start.
- Result(row,col) = sum over k,c,r,s of P[c][row+r-P][col+s-P] * W(k,c,r,s), with P=(K-1)/2 and out-of-range pixels = 0.
- Weights are fixed constants: W(k,c,r,s) = ((k + c + r*K + s) mod 2^weight_bits) - 2^(weight_bits-1), range -4..3.
- Multiply: pixel zero-extended, signed product, sign-extended sum; conv_result_bits never overflows.
- Output timing: conv_result_valid pulses 1 cycle, with conv_result and conv_result_addr stable during that cycle. First valid comes 26 cycles after the edge accepting the last pixel. Subsequent valids are exactly 25 cycles apart. conv_result/addr hold their last values between pulses.
- DONE: conv_finish=1 for exactly one cycle, the cycle after the last (addr 783) valid, then IDLE.
- If conv_start is still high in IDLE, a new frame starts (need_pic rises again).
- conv_start outside IDLE is ignored.
- pic_valid outside LOAD is ignored.

Decomposition:
- Shared package conv_pkg: state enum (IDLE, LOAD, COMPUTE, DONE) and a weight function W(k,c,r,s) parameterised on weight_bits/K.
- One natural sub-module: conv_weight_rom (combinational: tap index r,s -> all C*kernel_number signed weights).
- Top holds the pixel buffer, counters, FSM and MAC tree.

Test Plan:
- Reset then conv_start=1, pic_valid=1, pic=1 constant -> need_pic high ~2352 accepted cycles; 784 valids, addr 0..783 in order. Addr 0 (corner): result -11 (0x7F5). Interior (row,col in 2..25, e.g. addr 58): result -45 (0x7D3). conv_finish is one pulse after addr 783.
- All pixels 0 -> all 784 results 0, conv_finish pulses once.
- pic_valid toggled 1/0 every cycle, pic=1 -> load takes ~4704 cycles; results identical to first scenario.
- Impulse: c0 pixel (14,14)=3, others 0 -> addr 14*28+14 result 3*W(0,0,2,2) = 3*0 = 0. Addr 13*28+13 (tap r=s=3) result 3*(((18) mod 8)-4) = -6; all other addresses 0 or per formula.
- rst asserted mid-COMPUTE -> next cycle all outputs 0, state IDLE. A fresh run gives the scenario 1 values.
- conv_start held high -> after conv_finish, need_pic reasserts and a second frame yields identical results.
